// File: rtl/input_controller_pkg.sv
// Shared types and constants for the switch-input controller.
// INPUT_SIGN_EXT_EN selects sign extension of SW into DIN (zero extension when undefined).
package input_controller_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    // LCD menu code for the "enter input" prompt screen
    localparam logic [3:0] MENU_INPUT_WAIT = 4'd2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_RELEASE = 2'd1,
        WAIT_PRESS   = 2'd2,
        CAPTURE      = 2'd3
    } state_t;

    function automatic logic [31:0] extend_sw(input logic [15:0] sw);
`ifdef INPUT_SIGN_EXT_EN
        return {{16{sw[15]}}, sw};
`else
        return {16'b0, sw};
`endif
    endfunction

endpackage

// File: rtl/input_controller_if.sv
// CPU-side IN-instruction handshake between the core and the input controller.
interface input_controller_if;
    logic        inReq;
    logic [31:0] DIN;
    logic        inValid;
    logic        stall;
    logic        waiting;

    modport master (output inReq, input DIN, inValid, stall, waiting);
    modport slave  (input inReq, output DIN, inValid, stall, waiting);
endinterface

// File: rtl/input_controller_key_debouncer.sv
// Synchronizes and debounces an active-low pushbutton; emits a pulse on a debounced press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles; no backpressure (free-running).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic press_evt
);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            cnt       <= '0;
            key_level <= 1'b1;
            press_evt <= 1'b0;
        end else begin
            sync1     <= key_n;
            sync2     <= sync1;
            press_evt <= 1'b0;
            if (sync2 == key_level) begin
                cnt <= '0;
            end else if (cnt_done) begin
                cnt       <= '0;
                key_level <= sync2;
                // pulse coincides with the first cycle of the debounced low level
                press_evt <= key_level & ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_controller.sv
// Stalls the CPU during IN and captures SW into DIN on a debounced confirm press.
// Latency: inValid one cycle after press_evt; stall asserts combinationally with inReq.
module input_controller
    import input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic               clock,
    input  logic               iRST_N,
    input  logic               KEY_N,
    input  logic [15:0]        SW,
    input_controller_if.slave  cpu
);

    state_t      state;
    logic [31:0] din_q;
    logic        valid_q;
    logic        waiting_q;
    logic        key_level;
    logic        press_evt;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_deb (
        .clock     (clock),
        .rst_n     (iRST_N),
        .key_n     (KEY_N),
        .key_level (key_level),
        .press_evt (press_evt)
    );

    always_ff @(posedge clock or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            din_q     <= '0;
            valid_q   <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.inReq) begin
                        state     <= WAIT_RELEASE;
                        waiting_q <= 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    // a key still held from the previous IN must be released first
                    if (!cpu.inReq) begin
                        state     <= IDLE;
                        waiting_q <= 1'b0;
                    end else if (key_level) begin
                        state <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!cpu.inReq) begin
                        state     <= IDLE;
                        waiting_q <= 1'b0;
                    end else if (press_evt) begin
                        state     <= CAPTURE;
                        din_q     <= extend_sw(SW);
                        valid_q   <= 1'b1;
                        waiting_q <= 1'b0;
                    end
                end
                CAPTURE: begin
                    state     <= WAIT_RELEASE;
                    waiting_q <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    waiting_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.DIN     = din_q;
    assign cpu.inValid = valid_q;
    assign cpu.waiting = waiting_q;
    assign cpu.stall   = cpu.inReq && (state != CAPTURE);

endmodule

// File: tb/tb_input_controller.sv
module tb_input_controller;
    import input_controller_pkg::*;

    localparam int DEB = 4;

    logic        clock = 1'b0;
    logic        iRST_N;
    logic        KEY_N;
    logic [15:0] SW;

    input_controller_if bus ();

    input_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clock  (clock),
        .iRST_N (iRST_N),
        .KEY_N  (KEY_N),
        .SW     (SW),
        .cpu    (bus.slave)
    );

    always #5 clock = ~clock;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model_ext(input logic [15:0] s);
`ifdef INPUT_SIGN_EXT_EN
        return {{16{s[15]}}, s};
`else
        return {16'h0000, s};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: every inValid pulse must match the next queued expectation
    always @(negedge clock) begin
        if (iRST_N === 1'b1 && bus.inValid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_inValid", 32'd1, 32'd0);
            end else begin
                chk("din_scoreboard", bus.DIN, exp_q.pop_front());
                chk("stall_in_capture", {31'd0, bus.stall}, 32'd0);
                chk("waiting_in_capture", {31'd0, bus.waiting}, 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // waits for inValid; counts negedges from call until it is seen
    task automatic wait_valid(input string tag, input int max, input bit chk_stall, output int cycles);
        bit got = 0;
        cycles = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            cycles++;
            if (bus.inValid === 1'b1) begin
                got = 1;
                break;
            end
            if (chk_stall && i > 0) begin
                chk({tag, "_stall_pending"}, {31'd0, bus.stall}, 32'd1);
                chk({tag, "_waiting_pending"}, {31'd0, bus.waiting}, 32'd1);
            end
        end
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(negedge clock);
        chk({tag, "_valid_one_cycle"}, {31'd0, bus.inValid}, 32'd0);
        step(1);
    endtask

    task automatic release_all();
        bus.inReq = 1'b0;
        KEY_N     = 1'b1;
        step(12);
    endtask

    int cyc;
    int vc0;
    bit seen;

    initial begin
        iRST_N    = 1'b0;
        KEY_N     = 1'b1;
        SW        = 16'h0000;
        bus.inReq = 1'b0;
        step(2);
        @(negedge clock);
        chk("rst_din", bus.DIN, 32'd0);
        chk("rst_valid", {31'd0, bus.inValid}, 32'd0);
        chk("rst_waiting", {31'd0, bus.waiting}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        iRST_N = 1'b1;
        step(2);

        // basic capture
        SW        = 16'h0005;
        bus.inReq = 1'b1;
        @(negedge clock);
        chk("basic_stall_idle", {31'd0, bus.stall}, 32'd1);
        chk("basic_waiting_idle", {31'd0, bus.waiting}, 32'd0);
        step(1);
        @(negedge clock);
        chk("basic_waiting_on", {31'd0, bus.waiting}, 32'd1);
        step(2);
        exp_q.push_back(model_ext(16'h0005));
        KEY_N = 1'b0;
        wait_valid("basic", 20, 1'b1, cyc);
        chk("basic_din", bus.DIN, 32'h0000_0005);
        step(6);
        release_all();
        chk("basic_din_hold", bus.DIN, 32'h0000_0005);
        chk("basic_count", valid_cnt, 32'd1);

        // held key across back-to-back INs
        SW        = 16'h1111;
        bus.inReq = 1'b1;
        step(3);
        exp_q.push_back(model_ext(16'h1111));
        KEY_N = 1'b0;
        wait_valid("held1", 20, 1'b0, cyc);
        vc0 = valid_cnt;
        step(15);
        chk("held_no_repeat", valid_cnt, vc0);
        chk("held_stall", {31'd0, bus.stall}, 32'd1);
        SW    = 16'h1234;
        KEY_N = 1'b1;
        step(10);
        chk("held_no_valid_release", valid_cnt, vc0);
        exp_q.push_back(model_ext(16'h1234));
        KEY_N = 1'b0;
        wait_valid("held2", 20, 1'b1, cyc);
        chk("held2_din", bus.DIN, 32'h0000_1234);
        release_all();

        // bouncing key
        SW        = 16'h00A5;
        bus.inReq = 1'b1;
        step(4);
        vc0 = valid_cnt;
        for (int i = 0; i < 10; i++) begin
            KEY_N = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        step(2);
        chk("bounce_no_valid", valid_cnt, vc0);
        exp_q.push_back(model_ext(16'h00A5));
        KEY_N = 1'b0;
        wait_valid("bounce", 30, 1'b1, cyc);
        chk("bounce_latency_min", {31'd0, cyc >= DEB + 2}, 32'd1);
        chk("bounce_latency_max", {31'd0, cyc <= DEB + 4}, 32'd1);
        chk("bounce_one_pulse", valid_cnt, vc0 + 1);
        release_all();

        // abort: inReq drops in the press_evt cycle
        SW        = 16'h7777;
        bus.inReq = 1'b1;
        step(4);
        vc0   = valid_cnt;
        KEY_N = 1'b0;
        seen  = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (dut.u_deb.press_evt === 1'b1) begin
                seen = 1;
                break;
            end
        end
        chk("abort_press_seen", {31'd0, seen}, 32'd1);
        bus.inReq = 1'b0;
        @(negedge clock);
        chk("abort_stall", {31'd0, bus.stall}, 32'd0);
        step(1);
        @(negedge clock);
        chk("abort_state_idle", {30'd0, dut.state}, {30'd0, IDLE});
        chk("abort_waiting", {31'd0, bus.waiting}, 32'd0);
        step(5);
        chk("abort_no_valid", valid_cnt, vc0);
        chk("abort_din_kept", bus.DIN, model_ext(16'h00A5));
        release_all();

        // sign handling
        SW        = 16'hFFFE;
        bus.inReq = 1'b1;
        step(3);
        exp_q.push_back(model_ext(16'hFFFE));
        KEY_N = 1'b0;
        wait_valid("sign", 20, 1'b1, cyc);
`ifdef INPUT_SIGN_EXT_EN
        chk("sign_din", bus.DIN, 32'hFFFF_FFFE);
`else
        chk("sign_din", bus.DIN, 32'h0000_FFFE);
`endif
        release_all();

        // asynchronous reset during WAIT_PRESS
        bus.inReq = 1'b1;
        step(5);
        @(negedge clock);
        chk("rstmid_waiting_before", {31'd0, bus.waiting}, 32'd1);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("rstmid_din", bus.DIN, 32'd0);
        chk("rstmid_waiting", {31'd0, bus.waiting}, 32'd0);
        chk("rstmid_valid", {31'd0, bus.inValid}, 32'd0);
        chk("rstmid_stall_held", {31'd0, bus.stall}, 32'd1);
        bus.inReq = 1'b0;
        #1;
        chk("rstmid_stall_drop", {31'd0, bus.stall}, 32'd0);
        step(2);
        iRST_N = 1'b1;
        step(2);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
